// File: rtl/scara_cmd_pkg.sv
// Shared types for the G-code command queue: command encoding, field widths and queue FSM states.
package scara_cmd_pkg;

    localparam int CMD_W   = 4;
    localparam int COORD_W = 14;

    typedef enum logic [CMD_W-1:0] {
        CMD_G00 = 4'd0,
        CMD_G01 = 4'd1,
        CMD_G20 = 4'd2,
        CMD_G21 = 4'd3,
        CMD_G90 = 4'd4,
        CMD_G91 = 4'd5,
        CMD_M2  = 4'd6,
        CMD_M6  = 4'd7,
        CMD_M72 = 4'd8
    } cmd_t;

    typedef enum logic [1:0] {
        Q_IDLE,
        Q_RUN,
        Q_DONE
    } q_state_t;

    // Codes 9..15 have no meaning to the controller.
    function automatic logic cmd_known(input logic [CMD_W-1:0] code);
        return code <= CMD_M72;
    endfunction

endpackage

// File: rtl/cmd_queue_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after it is written.
// Backpressure: none; the owner gates the write enable.
module cmd_queue_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/gcode_cmd_queue.sv
// G-code command queue feeding the SCARA motion controller; M2 ends a run. Macro: GCODE_CMD_FILTER_EN.
// Latency: push visible at the head 1 cycle later (no fall-through).
// Backpressure: wr_ready drops when full or blocked; head held while controller_ready=0.
module gcode_cmd_queue
    import scara_cmd_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int COORD_W = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     block,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [3:0]               wr_cmd,
    input  logic [COORD_W-1:0]       wr_x,
    input  logic [COORD_W-1:0]       wr_y,
    input  logic                     controller_ready,
    output logic                     memory_ready,
    output logic [3:0]               cmd,
    output logic [COORD_W-1:0]       x_value,
    output logic [COORD_W-1:0]       y_value,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     program_done,
    output logic                     overflow,
    output logic                     bad_cmd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = CMD_W + 2 * COORD_W;

    q_state_t          state, state_nxt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt;
    logic              full, empty;
    logic              wr_fire, push, pop, m2_pop, head_is_m2;
    logic [EW-1:0]     head;
    logic [CMD_W-1:0]  head_cmd;
    logic [COORD_W-1:0] head_x, head_y;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    // Gating with rst_n keeps the loader stalled while reset is held.
    assign wr_ready = rst_n & ~full & ~block;
    assign wr_fire  = wr_valid & wr_ready;

`ifdef GCODE_CMD_FILTER_EN
    logic code_ok;
    assign code_ok = cmd_known(wr_cmd);
    assign push    = wr_fire & code_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_cmd <= 1'b0;
        end else if (wr_fire && !code_ok) begin
            bad_cmd <= 1'b1;
        end
    end
`else
    assign push    = wr_fire;
    assign bad_cmd = 1'b0;
`endif

    cmd_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({wr_cmd, wr_x, wr_y}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign head_cmd = head[EW-1 -: CMD_W];
    assign head_x   = head[2*COORD_W-1 -: COORD_W];
    assign head_y   = head[COORD_W-1:0];

    // M2 is consumed inside the queue; the controller never sees it.
    assign head_is_m2   = ~empty & (head_cmd == CMD_M2);
    assign memory_ready = (state == Q_RUN) & ~empty & ~head_is_m2;
    assign m2_pop       = (state == Q_RUN) & head_is_m2 & ~block;
    assign pop          = (memory_ready & controller_ready & ~block) | m2_pop;

    assign cmd          = memory_ready ? head_cmd : '0;
    assign x_value      = memory_ready ? head_x   : '0;
    assign y_value      = memory_ready ? head_y   : '0;
    assign count        = cnt;
    assign program_done = (state == Q_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (block) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_valid && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= Q_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (block) begin
            state_nxt = Q_IDLE;
        end else begin
            case (state)
                Q_IDLE:  if (start) state_nxt = Q_RUN;
                Q_RUN:   if (head_is_m2) state_nxt = Q_DONE;
                Q_DONE:  if (start) state_nxt = Q_RUN;
                default: state_nxt = Q_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcode_cmd_queue.sv
// Directed bench for gcode_cmd_queue; expected head entries go to a scoreboard drained by a monitor.
module tb_gcode_cmd_queue;

    localparam int DEPTH   = 16;
    localparam int COORD_W = 14;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic                   block;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [3:0]             wr_cmd;
    logic [COORD_W-1:0]     wr_x;
    logic [COORD_W-1:0]     wr_y;
    logic                   controller_ready;
    logic                   memory_ready;
    logic [3:0]             cmd;
    logic [COORD_W-1:0]     x_value;
    logic [COORD_W-1:0]     y_value;
    logic [$clog2(DEPTH):0] count;
    logic                   program_done;
    logic                   overflow;
    logic                   bad_cmd;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    gcode_cmd_queue #(
        .DEPTH   (DEPTH),
        .COORD_W (COORD_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .block            (block),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_cmd           (wr_cmd),
        .wr_x             (wr_x),
        .wr_y             (wr_y),
        .controller_ready (controller_ready),
        .memory_ready     (memory_ready),
        .cmd              (cmd),
        .x_value          (x_value),
        .y_value          (y_value),
        .count            (count),
        .program_done     (program_done),
        .overflow         (overflow),
        .bad_cmd          (bad_cmd)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted downstream command must match the oldest expected entry.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && memory_ready && controller_ready && !block) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL head_unexpected: got cmd=%0d x=%0d y=%0d, required no command", cmd, x_value, y_value);
            end else begin
                e = exp_q.pop_front();
                if ({cmd, x_value, y_value} !== e) begin
                    fails++;
                    $display("FAIL head_entry: got cmd=%0d x=%0d y=%0d, required cmd=%0d x=%0d y=%0d",
                             cmd, x_value, y_value, e[31:28], e[27:14], e[13:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [3:0] c, input logic [13:0] x, input logic [13:0] y, input bit track);
        wr_valid = 1'b1;
        wr_cmd   = c;
        wr_x     = x;
        wr_y     = y;
        if (track) exp_q.push_back({c, x, y});
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_block();
        block = 1'b1;
        step();
        block = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; block = 1'b0; wr_valid = 1'b0;
        wr_cmd = '0; wr_x = '0; wr_y = '0; controller_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_memory_ready", memory_ready, 0);
        check("rst_count", count, 0);
        check("rst_program_done", program_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_bad_cmd", bad_cmd, 0);
        check("rst_cmd", {cmd, x_value, y_value}, 0);
        rst_n = 1'b1;
        controller_ready = 1'b1;
        step();
        check("idle_wr_ready", wr_ready, 1);

        // Preload G20, G01(100,200), M2, then run.
        push_entry(4'd2, 14'd0, 14'd0, 1);
        push_entry(4'd1, 14'd100, 14'd200, 1);
        push_entry(4'd6, 14'd0, 14'd0, 0);
        check("preload_count", count, 3);
        check("preload_idle_memory_ready", memory_ready, 0);
        pulse_start();
        check("run_memory_ready", memory_ready, 1);
        check("run_first_cmd", cmd, 2);
        for (int i = 0; i < 10 && !program_done; i++) step();
        check("done_program_done", program_done, 1);
        check("done_memory_ready", memory_ready, 0);
        check("done_count", count, 0);

        // Backpressure with three entries loaded from DONE.
        controller_ready = 1'b0;
        push_entry(4'd0, 14'd1, 14'd2, 1);
        push_entry(4'd4, 14'd0, 14'd0, 1);
        push_entry(4'd8, 14'd3, 14'd4, 1);
        check("done_accepts_count", count, 3);
        pulse_start();
        repeat (5) step();
        check("bp_count", count, 3);
        check("bp_head", {cmd, x_value, y_value}, {4'd0, 14'd1, 14'd2});
        controller_ready = 1'b1;
        step();
        check("bp_pop1_count", count, 2);
        check("bp_pop1_cmd", cmd, 4);
        step();
        check("bp_pop2_count", count, 1);
        check("bp_pop2_cmd", cmd, 8);
        step();
        check("bp_empty_count", count, 0);
        check("bp_empty_memory_ready", memory_ready, 0);

        // Fill to DEPTH in IDLE, then overflow.
        pulse_block();
        check("blk_count", count, 0);
        check("blk_program_done", program_done, 0);
        controller_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_entry(4'(i % 6), 14'(i * 3), 14'(i * 5 + 1), 1);
        check("full_count", count, 16);
        check("full_wr_ready", wr_ready, 0);
        push_entry(4'd3, 14'd99, 14'd99, 0);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 16);

        // Simultaneous push and pop at 15, then at 1 across the pointer wrap.
        pulse_start();
        controller_ready = 1'b1;
        step();
        check("pop_to_15", count, 15);
        push_entry(4'd7, 14'd7, 14'd0, 1);
        check("pushpop_15", count, 15);
        repeat (14) step();
        check("drain_to_1", count, 1);
        push_entry(4'd8, 14'h3fff, 14'h2aaa, 1);
        check("pushpop_1_count", count, 1);
        check("wrap_head", {cmd, x_value, y_value}, {4'd8, 14'h3fff, 14'h2aaa});
        step();
        check("wrap_drained", count, 0);

        // Block mid-run with five entries queued.
        controller_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_entry(4'd1, 14'(i), 14'(i), 0);
        check("mid_count", count, 5);
        check("mid_memory_ready", memory_ready, 1);
        pulse_block();
        check("abort_count", count, 0);
        check("abort_memory_ready", memory_ready, 0);
        check("abort_overflow_kept", overflow, 1);
        push_entry(4'd1, 14'd9, 14'd9, 0);
        step();
        check("abort_idle_no_present", memory_ready, 0);
        check("abort_idle_count", count, 1);
        pulse_block();

        // Unknown code 12.
        push_entry(4'd12, 14'd5, 14'd5, 0);
`ifdef GCODE_CMD_FILTER_EN
        check("unknown_count", count, 0);
        check("unknown_bad_cmd", bad_cmd, 1);
`else
        check("unknown_count", count, 1);
        check("unknown_bad_cmd", bad_cmd, 0);
`endif
        pulse_block();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
